pcileech_tlp_rx_unpack64: RTL and testbench
===========================================

Name: pcileech_tlp_rx_unpack64

Overview:
- Downstream of the Artix-7 PCIe core's 64-bit m_axis_rx receive stream; consumes those beats.
- Converts each 64-bit beat into a 32-bit DW stream with first/last markers, ready for the 32-bit TLP FIFO path toward the host.
- Full-rate: sustains one DW per clock, with backpressure in both directions.
- Enforces a maximum TLP length by truncating oversize TLPs and flagging an error.

Parameters:
MAX_DW, 1028, maximum DWs emitted per TLP (header plus payload); must be ≥4. Internal DW counter width is $clog2(MAX_DW+1).
STAT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
clk_pcie  in  1  PCIe user clock
rst  in  1  asynchronous, active-high reset
m_axis_rx_tdata  in  64  receive beat; DW0 = [31:0], DW1 = [63:32]
m_axis_rx_tkeep  in  8  byte enables; only bit 4 is consulted, and only on the last beat
m_axis_rx_tlast  in  1  last beat of TLP
m_axis_rx_tvalid  in  1  beat valid
m_axis_rx_tready  out  1  beat accepted when tvalid & tready
rx_dw_data  out  32  output DW
rx_dw_valid  out  1  output DW valid
rx_dw_first  out  1  DW is the first DW of its TLP
rx_dw_last  out  1  DW is the last DW of its TLP (natural or forced)
rx_dw_ready  in  1  consumer accepts DW when valid & ready
err_oversize  out  1  one-cycle pulse when a TLP is truncated
stat_tlp_count  out  STAT_W  TLPs emitted (optional feature only)
stat_trunc_count  out  STAT_W  TLPs truncated (optional feature only)

Behaviour:
- Interface: one clock, clk_pcie. Reset rst is asynchronous and active-high.
- Reset values:
  - All outputs 0: m_axis_rx_tready, rx_dw_*, err_oversize, stat counters.
  - Internal state: buffer empty, ptr=0, dw_cnt=0, first_pend=1, state S_PASS.
- One-beat buffer holds: buf_data[63:0], buf_n (1 or 2 DWs), buf_last, ptr (0=low, 1=high), buf_full.
- Beat width rule:
  - buf_n = 2 on non-last beats.
  - On a last beat, buf_n = 1 if tkeep[4]=0, else 2.
- Outputs in S_PASS:
  - rx_dw_valid = buf_full.
  - rx_dw_data = ptr ? buf_data[63:32] : buf_data[31:0].
  - rx_dw_first = first_pend.
  - rx_dw_last = (buf_last & ptr==buf_n-1) | (dw_cnt==MAX_DW-1).
- Input ready (combinational through rx_dw_ready):
  - m_axis_rx_tready = ~buf_full | (rx_dw_valid & rx_dw_ready & ptr==buf_n-1 & ~force_trunc) in S_PASS.
  - m_axis_rx_tready = 1 in S_DISCARD.
- Simultaneous accept: a beat is loaded with ptr=0 in the same cycle the final buffered DW is consumed, so there is no bubble.
- Latency: first DW of an accepted beat is valid the next cycle.
- DW accept, S_PASS (rx_dw_valid & rx_dw_ready):
  - ptr advances, or the buffer empties on the beat's final DW.
  - dw_cnt increments; first_pend clears.
  - On rx_dw_last: dw_cnt=0 and first_pend=1.
- Truncation (force_trunc = dw_cnt==MAX_DW-1 and not the natural last), on accept of the forced-last DW:
  - Buffer is cleared; err_oversize pulses for one cycle.
  - If the buffer's natural tlast has not yet been accepted, enter S_DISCARD; otherwise stay in S_PASS.
  - A natural last landing exactly on DW MAX_DW is not a truncation.
- S_DISCARD:
  - Accept and drop beats.
  - rx_dw_valid = 0.
  - On accepted tlast, return to S_PASS with the buffer empty.
- Stall: when rx_dw_ready=0, rx_dw_* stay stable and no new beat is accepted.
- Reset mid-TLP: all state returns to reset values. The partial TLP is abandoned, and the next beat is treated as the start of a new TLP.

Optional Feature:
- Macro: PCILEECH_TLP_RX_STATS_EN.
- Defined:
  - stat_tlp_count increments on every accepted rx_dw_last.
  - stat_trunc_count increments on every err_oversize.
  - Both counters wrap modulo 2^STAT_W.
- Undefined: both stat outputs are tied to 0 and no counter registers are synthesised.

Decomposition:
- Shared package pcileech_tlp_pkg holds:
  - typedef enum {S_PASS, S_DISCARD} state type.
  - DW_W=32 and BEAT_W=64 constants.
  - A typedef packed struct for the buffered beat (data, n, last).
- No sub-module needed; if the stats logic is split out, it goes in pcileech_tlp_rx_stats.

Test Plan:
1. 3-DW TLP (beat0 tkeep=FF; beat1 tlast, tkeep=0F) with rx_dw_ready=1 → 3 DWs on consecutive cycles, first on DW0, last on DW2, no gaps.
2. Back-to-back 4-DW TLPs, tvalid held high → 8 consecutive DWs with tready=1 every other cycle; first/last toggle at DW0/3/4/7.
3. rx_dw_ready random (50%) on a 10-DW TLP → DW order exact, outputs stable during stalls, no beat lost.
4. MAX_DW=8, 12-DW TLP → DWs 0–7 emitted, DW7 last=1, err_oversize pulses once, remaining beats dropped, next TLP starts with first=1.
5. MAX_DW=8, exactly 8-DW TLP → no err_oversize, DW7 natural last.
6. rst asserted while DW2 of 6 is stalled → all outputs 0 immediately; after release a new 2-DW TLP emits with correct first/last; stats (if enabled) read 1 TLP, 0 truncs.

Source files
------------

// File: rtl/pcileech_tlp_rx_unpack64_pkg.sv
// Shared types and constants for the 64-bit RX beat to 32-bit DW unpacker.
package pcileech_tlp_pkg;

  localparam int unsigned DW_W   = 32;
  localparam int unsigned BEAT_W = 64;

  typedef enum logic {
    S_PASS    = 1'b0,
    S_DISCARD = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [1:0]        n;
    logic              last;
  } rx_beat_t;

  // Only a last beat may carry a single DW; its upper DW is then flagged by keep byte 4.
  function automatic logic [1:0] beat_dw_count(input logic tlast, input logic keep_hi);
    return (tlast && !keep_hi) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/pcileech_tlp_rx_unpack64_if.sv
// Beat-in / DW-out handshake bundle; 'slave' is the unpacker's view, 'master' the surroundings.
interface pcileech_tlp_rx_unpack64_if;
  import pcileech_tlp_pkg::*;

  logic [BEAT_W-1:0] m_axis_rx_tdata;
  logic [7:0]        m_axis_rx_tkeep;
  logic              m_axis_rx_tlast;
  logic              m_axis_rx_tvalid;
  logic              m_axis_rx_tready;

  logic [DW_W-1:0]   rx_dw_data;
  logic              rx_dw_valid;
  logic              rx_dw_first;
  logic              rx_dw_last;
  logic              rx_dw_ready;

  modport slave (
    input  m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
    output m_axis_rx_tready,
    output rx_dw_data, rx_dw_valid, rx_dw_first, rx_dw_last,
    input  rx_dw_ready
  );

  modport master (
    output m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
    input  m_axis_rx_tready,
    input  rx_dw_data, rx_dw_valid, rx_dw_first, rx_dw_last,
    output rx_dw_ready
  );

endinterface

// File: rtl/pcileech_tlp_rx_unpack64.sv
// Unpacks 64-bit PCIe RX beats into a DW stream, truncating TLPs longer than MAX_DW.
// Optional statistics counters are built when PCILEECH_TLP_RX_STATS_EN is defined.
module pcileech_tlp_rx_unpack64
  import pcileech_tlp_pkg::*;
#(
  parameter int unsigned MAX_DW = 1028,
  parameter int unsigned STAT_W = 32
) (
  input  logic                     clk_pcie,
  input  logic                     rst,
  pcileech_tlp_rx_unpack64_if.slave bus,
  output logic                     err_oversize,
  output logic [STAT_W-1:0]        stat_tlp_count,
  output logic [STAT_W-1:0]        stat_trunc_count
);

  localparam int unsigned          CNT_W    = $clog2(MAX_DW + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAX_DW - 1);

  rx_state_e        state;
  rx_beat_t         buf_q;
  logic             buf_full;
  logic             ptr;
  logic             first_pend;
  logic             out_en;
  logic [CNT_W-1:0] dw_cnt;

  logic ptr_at_end;
  logic nat_last;
  logic at_max;
  logic force_trunc;
  logic dw_valid;
  logic dw_last;
  logic dw_acc;
  logic tready;
  logic beat_acc;
  logic unused_keep;

  always_comb begin
    ptr_at_end  = ({1'b0, ptr} == (buf_q.n - 2'd1));
    nat_last    = buf_q.last & ptr_at_end;
    at_max      = (dw_cnt == CNT_LAST);
    force_trunc = at_max & ~nat_last;
    dw_valid    = (state == S_PASS) & buf_full;
    dw_last     = dw_valid & (nat_last | at_max);
    dw_acc      = dw_valid & bus.rx_dw_ready;
    // out_en holds tready low until the first clock after reset; refill is allowed
    // in the same cycle the final buffered DW leaves, but never on a forced last.
    tready      = out_en & ((state == S_DISCARD) | ~buf_full |
                            (dw_acc & ptr_at_end & ~force_trunc));
    beat_acc    = bus.m_axis_rx_tvalid & tready;
  end

  assign unused_keep = ^{bus.m_axis_rx_tkeep[7:5], bus.m_axis_rx_tkeep[3:0]};

  assign bus.m_axis_rx_tready = tready;
  assign bus.rx_dw_valid      = dw_valid;
  assign bus.rx_dw_data       = dw_valid ? (ptr ? buf_q.data[63:32] : buf_q.data[31:0]) : '0;
  assign bus.rx_dw_first      = dw_valid & first_pend;
  assign bus.rx_dw_last       = dw_last;

  always_ff @(posedge clk_pcie or posedge rst) begin
    if (rst) begin
      state        <= S_PASS;
      buf_q        <= '0;
      buf_full     <= 1'b0;
      ptr          <= 1'b0;
      first_pend   <= 1'b1;
      out_en       <= 1'b0;
      dw_cnt       <= '0;
      err_oversize <= 1'b0;
    end else begin
      out_en       <= 1'b1;
      err_oversize <= dw_acc & force_trunc;
      case (state)
        S_PASS: begin
          if (dw_acc) begin
            if (dw_last) begin
              dw_cnt     <= '0;
              first_pend <= 1'b1;
            end else begin
              dw_cnt     <= dw_cnt + 1'b1;
              first_pend <= 1'b0;
            end
            if (ptr_at_end | force_trunc) begin
              buf_full <= 1'b0;
              ptr      <= 1'b0;
            end else begin
              ptr <= 1'b1;
            end
            // Remaining beats of a truncated TLP are still upstream unless its tlast is buffered.
            if (force_trunc & ~buf_q.last)
              state <= S_DISCARD;
          end
          if (beat_acc) begin
            buf_q.data <= bus.m_axis_rx_tdata;
            buf_q.n    <= beat_dw_count(bus.m_axis_rx_tlast, bus.m_axis_rx_tkeep[4]);
            buf_q.last <= bus.m_axis_rx_tlast;
            buf_full   <= 1'b1;
            ptr        <= 1'b0;
          end
        end
        S_DISCARD: begin
          if (beat_acc & bus.m_axis_rx_tlast)
            state <= S_PASS;
        end
        default: state <= S_PASS;
      endcase
    end
  end

`ifdef PCILEECH_TLP_RX_STATS_EN
  always_ff @(posedge clk_pcie or posedge rst) begin
    if (rst) begin
      stat_tlp_count   <= '0;
      stat_trunc_count <= '0;
    end else begin
      if (dw_acc & dw_last)
        stat_tlp_count <= stat_tlp_count + 1'b1;
      if (dw_acc & force_trunc)
        stat_trunc_count <= stat_trunc_count + 1'b1;
    end
  end
`else
  assign stat_tlp_count   = '0;
  assign stat_trunc_count = '0;
`endif

endmodule

// File: tb/tb_pcileech_tlp_rx_unpack64.sv
// Randomised bench for pcileech_tlp_rx_unpack64 against a per-TLP expected-DW queue.
module tb_pcileech_tlp_rx_unpack64;

  localparam int unsigned MAX_DW = 8;

  logic        clk_pcie = 1'b0;
  logic        rst      = 1'b1;
  logic        err_oversize;
  logic [31:0] stat_tlp_count;
  logic [31:0] stat_trunc_count;

  always #5 clk_pcie = ~clk_pcie;

  pcileech_tlp_rx_unpack64_if bus();

  pcileech_tlp_rx_unpack64 #(.MAX_DW(MAX_DW), .STAT_W(32)) dut (
    .clk_pcie         (clk_pcie),
    .rst              (rst),
    .bus              (bus),
    .err_oversize     (err_oversize),
    .stat_tlp_count   (stat_tlp_count),
    .stat_trunc_count (stat_trunc_count)
  );

  typedef struct {
    logic [31:0] data;
    logic        first;
    logic        last;
    logic        trunc;
  } exp_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    logic        first;
    logic        last;
  } log_t;

  exp_t        exp_q[$];
  log_t        acc_log[$];
  exp_t        e;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned err_seen = 0;
  int unsigned exp_tlp = 0;
  int unsigned exp_trunc = 0;
  int unsigned rdy_mode = 0;
  int unsigned err_base;
  logic        pend_err = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] st_data;
  logic        st_first, st_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Consumer ready: 0 = held low, 1 = held high, 2 = random 50%.
  initial begin
    bus.rx_dw_ready = 1'b0;
    forever begin
      @(posedge clk_pcie);
      #2;
      bus.rx_dw_ready = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom % 2);
    end
  end

  always @(negedge clk_pcie) begin
    if (rst) begin
      pend_err   = 1'b0;
      stall_prev = 1'b0;
      exp_tlp    = 0;
      exp_trunc  = 0;
    end else begin
      cyc++;
      chk("err_oversize", 64'(err_oversize), 64'(pend_err));
      if (err_oversize) err_seen++;
      pend_err = 1'b0;
`ifdef PCILEECH_TLP_RX_STATS_EN
      chk("stat_tlp_count", 64'(stat_tlp_count), 64'(exp_tlp));
      chk("stat_trunc_count", 64'(stat_trunc_count), 64'(exp_trunc));
`else
      chk("stat_tlp_count", 64'(stat_tlp_count), 64'd0);
      chk("stat_trunc_count", 64'(stat_trunc_count), 64'd0);
`endif
      if (stall_prev)
        chk("stall_hold", {29'd0, bus.rx_dw_valid, bus.rx_dw_first, bus.rx_dw_last, bus.rx_dw_data},
            {29'd0, 1'b1, st_first, st_last, st_data});
      stall_prev = 1'b0;
      if (bus.rx_dw_valid) begin
        if (bus.rx_dw_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_dw", 64'(bus.rx_dw_data), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("dw", {30'd0, bus.rx_dw_data, bus.rx_dw_first, bus.rx_dw_last},
                {30'd0, e.data, e.first, e.last});
            if (e.last) exp_tlp++;
            if (e.trunc) begin
              exp_trunc++;
              pend_err = 1'b1;
            end
          end
          acc_log.push_back('{cyc, bus.rx_dw_data, bus.rx_dw_first, bus.rx_dw_last});
        end else begin
          stall_prev = 1'b1;
          st_data    = bus.rx_dw_data;
          st_first   = bus.rx_dw_first;
          st_last    = bus.rx_dw_last;
        end
      end
    end
  end

  task automatic wait_accept();
    bit done = 0;
    for (int unsigned n = 0; n < 2000 && !done; n++) begin
      @(negedge clk_pcie);
      if (bus.m_axis_rx_tready) done = 1;
    end
    if (!done) chk("beat_accept_timeout", 64'd0, 64'd1);
    @(posedge clk_pcie);
    #1;
  endtask

  task automatic send_tlp(input int unsigned len, input logic [31:0] base,
                          input bit rnd_data, input bit bubbles);
    logic [31:0] dws[$];
    logic [31:0] hi;
    logic [7:0]  k;
    int unsigned n_out, beats;
    for (int unsigned i = 0; i < len; i++)
      dws.push_back(rnd_data ? $urandom : base + i);
    n_out = (len > MAX_DW) ? MAX_DW : len;
    for (int unsigned i = 0; i < n_out; i++)
      exp_q.push_back('{dws[i], i == 0, i == n_out - 1, (len > MAX_DW) && (i == n_out - 1)});
    beats = (len + 1) / 2;
    for (int unsigned b = 0; b < beats; b++) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        bus.m_axis_rx_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk_pcie);
          #1;
        end
      end
      hi = (2 * b + 1 < len) ? dws[2 * b + 1] : $urandom;
      k  = 8'($urandom);
      if (b == beats - 1) k[4] = (len % 2 == 0);
      bus.m_axis_rx_tdata  = {hi, dws[2 * b]};
      bus.m_axis_rx_tkeep  = k;
      bus.m_axis_rx_tlast  = (b == beats - 1);
      bus.m_axis_rx_tvalid = 1'b1;
      wait_accept();
    end
    bus.m_axis_rx_tvalid = 1'b0;
    bus.m_axis_rx_tlast  = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk_pcie);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk_pcie);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m_axis_rx_tdata  = '0;
    bus.m_axis_rx_tkeep  = '0;
    bus.m_axis_rx_tlast  = 1'b0;
    bus.m_axis_rx_tvalid = 1'b0;
    repeat (2) @(posedge clk_pcie);
    #1;
    chk("rst_valid", 64'(bus.rx_dw_valid), 64'd0);
    chk("rst_tready", 64'(bus.m_axis_rx_tready), 64'd0);
    chk("rst_first_last", {62'd0, bus.rx_dw_first, bus.rx_dw_last}, 64'd0);
    chk("rst_data", 64'(bus.rx_dw_data), 64'd0);
    chk("rst_err", 64'(err_oversize), 64'd0);
    rst = 1'b0;
    rdy_mode = 1;
    @(posedge clk_pcie);
    #1;

    // 3-DW TLP at full rate
    acc_log.delete();
    send_tlp(3, 32'hA000_0000, 0, 0);
    drain();
    chk("t1_count", 64'(acc_log.size()), 64'd3);
    chk("t1_span", 64'(acc_log[2].cyc - acc_log[0].cyc), 64'd2);
    chk("t1_dw0", {30'd0, acc_log[0].data, acc_log[0].first, acc_log[0].last}, {30'd0, 32'hA000_0000, 2'b10});
    chk("t1_dw2", {30'd0, acc_log[2].data, acc_log[2].first, acc_log[2].last}, {30'd0, 32'hA000_0002, 2'b01});

    // back-to-back 4-DW TLPs
    acc_log.delete();
    send_tlp(4, 32'hB000_0000, 0, 0);
    send_tlp(4, 32'hC000_0000, 0, 0);
    drain();
    chk("t2_count", 64'(acc_log.size()), 64'd8);
    chk("t2_span", 64'(acc_log[7].cyc - acc_log[0].cyc), 64'd7);
    for (int unsigned i = 0; i < 8; i++)
      chk("t2_flags", {62'd0, acc_log[i].first, acc_log[i].last}, {62'd0, i % 4 == 0, i % 4 == 3});

    // 10-DW TLP under random consumer stalls, truncated at MAX_DW
    rdy_mode = 2;
    acc_log.delete();
    err_base = err_seen;
    send_tlp(10, 32'hD000_0000, 0, 1);
    send_tlp(3, 32'hE000_0000, 0, 1);
    drain();
    chk("t3_count", 64'(acc_log.size()), 64'd11);
    chk("t3_dw7_last", 64'(acc_log[7].last), 64'd1);
    chk("t3_next_first", {31'd0, acc_log[8].data, acc_log[8].first}, {31'd0, 32'hE000_0000, 1'b1});
    chk("t3_err_pulses", 64'(err_seen - err_base), 64'd1);

    // 12-DW TLP truncated, then exact MAX_DW TLP
    rdy_mode = 1;
    acc_log.delete();
    err_base = err_seen;
    send_tlp(12, 32'h5000_0000, 0, 0);
    send_tlp(2, 32'h6000_0000, 0, 0);
    drain();
    chk("t4_count", 64'(acc_log.size()), 64'd10);
    chk("t4_dw7", {31'd0, acc_log[7].data, acc_log[7].last}, {31'd0, 32'h5000_0007, 1'b1});
    chk("t4_next_first", 64'(acc_log[8].first), 64'd1);
    chk("t4_err_pulses", 64'(err_seen - err_base), 64'd1);

    acc_log.delete();
    err_base = err_seen;
    send_tlp(8, 32'h7000_0000, 0, 0);
    drain();
    chk("t5_count", 64'(acc_log.size()), 64'd8);
    chk("t5_dw7_last", 64'(acc_log[7].last), 64'd1);
    chk("t5_err_pulses", 64'(err_seen - err_base), 64'd0);

    // random lengths, bubbles and stalls
    rdy_mode = 2;
    for (int unsigned t = 0; t < 60; t++)
      send_tlp($urandom_range(1, 12), 32'h0, 1, 1);
    drain();

    // reset while DW2 of a 6-DW TLP is stalled
    rdy_mode = 0;
    @(posedge clk_pcie);
    #1;
    exp_q.push_back('{32'hF000_0000, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{32'hF000_0001, 1'b0, 1'b0, 1'b0});
    bus.m_axis_rx_tdata  = {32'hF000_0001, 32'hF000_0000};
    bus.m_axis_rx_tkeep  = 8'hFF;
    bus.m_axis_rx_tlast  = 1'b0;
    bus.m_axis_rx_tvalid = 1'b1;
    wait_accept();
    bus.m_axis_rx_tdata = {32'hF000_0003, 32'hF000_0002};
    rdy_mode = 1;
    @(posedge clk_pcie);
    #1;
    @(negedge clk_pcie);
    chk("t6_simul_accept", 64'(bus.m_axis_rx_tready), 64'd1);
    @(posedge clk_pcie);
    #1;
    bus.m_axis_rx_tvalid = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clk_pcie);
    #1;
    chk("t6_stalled_dw2", {31'd0, bus.rx_dw_valid, bus.rx_dw_data}, {31'd0, 1'b1, 32'hF000_0002});
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.rx_dw_valid), 64'd0);
    chk("t6_rst_data", 64'(bus.rx_dw_data), 64'd0);
    chk("t6_rst_first_last", {62'd0, bus.rx_dw_first, bus.rx_dw_last}, 64'd0);
    chk("t6_rst_tready", 64'(bus.m_axis_rx_tready), 64'd0);
    chk("t6_rst_stats", {stat_tlp_count, stat_trunc_count}, 64'd0);
    exp_q.delete();
    acc_log.delete();
    repeat (2) @(posedge clk_pcie);
    #1;
    rst = 1'b0;
    rdy_mode = 1;
    send_tlp(2, 32'h1234_0000, 0, 0);
    drain();
    chk("t6_count", 64'(acc_log.size()), 64'd2);
    chk("t6_flags", {60'd0, acc_log[0].first, acc_log[0].last, acc_log[1].first, acc_log[1].last},
        {60'd0, 4'b1001});
`ifdef PCILEECH_TLP_RX_STATS_EN
    chk("t6_stat_tlp", 64'(stat_tlp_count), 64'd1);
`else
    chk("t6_stat_tlp", 64'(stat_tlp_count), 64'd0);
`endif
    chk("t6_stat_trunc", 64'(stat_trunc_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
